// File: rtl/mmio_seq_multiplier.sv
// mmio_seq_multiplier
//   Memory-mapped shift-add multiplier. Registers: 0=A, 1=B (write starts),
//   2=product (read only), 3=status {err, done, busy} / control (write clears).
//   Optional feature macro: MMIO_MULT_ACCUM_EN -- when defined, each result
//   is accumulated into the product register (modulo 2^(2*WIDTH)), and an
//   addr3 write with din[0]=1 also clears the product.
module mmio_seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 e,
  input  logic [WIDTH-1:0]     din,
  input  logic [1:0]           addr,
  input  logic                 w,
  input  logic                 r,
  output logic [2*WIDTH-1:0]   dout,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [WIDTH-1:0]   ZERO_W  = {WIDTH{1'b0}};
  localparam logic [2*WIDTH-1:0] ZERO_2W = {(2*WIDTH){1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_r;
  logic [WIDTH-1:0]     a_r;
  logic [WIDTH-1:0]     b_r;
  logic [WIDTH-1:0]     mplier_r;   // multiplier, shifted right one bit per cycle
  logic [2*WIDTH-1:0]   mcand_r;    // A << k for the current bit k
  logic [2*WIDTH-1:0]   acc_r;      // partial product
  logic [2*WIDTH-1:0]   prod_r;
  logic [2*WIDTH-1:0]   dout_r;
  logic [CW-1:0]        cnt_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 err_r;

  logic                 wr_s;
  logic                 rd_s;
  logic                 last_s;
  logic [2*WIDTH-1:0]   sum_s;
  logic [2*WIDTH-1:0]   fin_s;
  logic [2*WIDTH-1:0]   rdata_s;

  assign dout = dout_r;
  assign busy = busy_r;
  assign done = done_r;

  // Strobe decode, next partial sum, completion value and read mux.
  always_comb begin
    wr_s    = e & w;
    rd_s    = e & r & ~w;
    last_s  = (cnt_r == CNT_LAST);
    sum_s   = ZERO_2W;
    fin_s   = ZERO_2W;
    rdata_s = ZERO_2W;
    if (mplier_r[0]) begin
      sum_s = acc_r + mcand_r;
    end else begin
      sum_s = acc_r;
    end
`ifdef MMIO_MULT_ACCUM_EN
    fin_s = prod_r + sum_s;
`else
    fin_s = sum_s;
`endif
    case (addr)
      2'd0:    rdata_s = {ZERO_W, a_r};
      2'd1:    rdata_s = {ZERO_W, b_r};
      2'd2:    rdata_s = prod_r;
      2'd3:    rdata_s = {{(2*WIDTH-3){1'b0}}, err_r, done_r, busy_r};
      default: rdata_s = ZERO_2W;
    endcase
  end

  // Control FSM, shift-add datapath and registered host interface.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      a_r      <= ZERO_W;
      b_r      <= ZERO_W;
      mplier_r <= ZERO_W;
      mcand_r  <= ZERO_2W;
      acc_r    <= ZERO_2W;
      prod_r   <= ZERO_2W;
      dout_r   <= ZERO_2W;
      cnt_r    <= CNT_ZERO;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      if (rd_s) begin
        dout_r <= rdata_s;
      end
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (wr_s) begin
            case (addr)
              2'd0: a_r <= din;
              2'd1: begin
                b_r      <= din;
                mplier_r <= din;
                mcand_r  <= {ZERO_W, a_r};
                acc_r    <= ZERO_2W;
                cnt_r    <= CNT_ZERO;
                done_r   <= 1'b0;
                busy_r   <= 1'b1;
                state_r  <= ST_RUN;
              end
              2'd3: begin
                err_r   <= 1'b0;
                done_r  <= 1'b0;
                state_r <= ST_IDLE;
`ifdef MMIO_MULT_ACCUM_EN
                if (din[0]) begin
                  prod_r <= ZERO_2W;
                end
`endif
              end
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          acc_r    <= sum_s;
          mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
          mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
          cnt_r    <= cnt_r + CNT_ONE;
          // Operand writes are refused while running; the run is untouched.
          if (wr_s) begin
            case (addr)
              2'd0, 2'd1: err_r <= 1'b1;
              2'd3: begin
                err_r  <= 1'b0;
                done_r <= 1'b0;
`ifdef MMIO_MULT_ACCUM_EN
                if (din[0]) begin
                  prod_r <= ZERO_2W;
                end
`endif
              end
              default: ;
            endcase
          end
          // Completion takes priority over a coincident status write.
          if (last_s) begin
            prod_r  <= fin_s;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule
